// File: rtl/mips_run_pkg.sv
// Shared state encoding and default widths for the MIPS run controller.
package mips_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RST_HOLD = 3'd1,
        S_LOAD     = 3'd2,
        S_RUN      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_CNT_W        = 32;
    localparam int DEF_RESET_CYCLES = 4;
    localparam int DEF_MAX_CYCLES   = 100000;

endpackage

// File: rtl/mips_cycle_counter.sv
// Up/down counter with clear, load, enable and a terminal-count compare.
module mips_cycle_counter #(
    parameter int W    = 32,
    parameter bit DOWN = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] count,
    output logic         tc
);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= DOWN ? count - 1'b1 : count + 1'b1;
        end
    end

    assign tc = (count == tc_val);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller: holds the MIPS core in reset, streams a program into imem,
// then runs the core until it halts or the cycle budget is exhausted.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   load_len,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic              core_halt,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int              RC_W    = $clog2(RESET_CYCLES) + 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] wcnt_q;
    logic [ADDR_W:0] len_clamped;
    logic [RC_W-1:0] hold_cnt;
    logic            hold_tc;
    logic            run_tc;
    logic            start_acc;
    logic            hs;
    logic            last_word;

    assign start_acc   = start && !abort && (state == S_IDLE || state == S_DONE);
    assign hs          = prog_valid && prog_ready;
    assign last_word   = hs && (wcnt_q == len_q - 1'b1);
    // The word counter is one bit wider than the address so a full-size load never wraps.
    assign len_clamped = (load_len > MAX_LEN) ? MAX_LEN : load_len;

    assign imem_we    = hs;
    assign imem_addr  = wcnt_q[ADDR_W-1:0];
    assign imem_wdata = prog_ready ? prog_data : '0;

    mips_cycle_counter #(.W(RC_W), .DOWN(1'b1)) u_hold_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (start_acc),
        .load_val (RC_W'(RESET_CYCLES - 1)),
        .en       ((state == S_RST_HOLD) && (hold_cnt != '0)),
        .tc_val   ('0),
        .count    (hold_cnt),
        .tc       (hold_tc)
    );

    // Terminal count one below the budget: the increment on that cycle lands on MAX_CYCLES.
    mips_cycle_counter #(.W(CNT_W), .DOWN(1'b0)) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (start_acc),
        .load     (1'b0),
        .load_val ('0),
        .en       (state == S_RUN),
        .tc_val   (CNT_W'(MAX_CYCLES - 1)),
        .count    (cycle_cnt),
        .tc       (run_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len_q      <= '0;
            wcnt_q     <= '0;
            prog_ready <= 1'b0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else if (abort) begin
            state      <= S_IDLE;
            prog_ready <= 1'b0;
            core_rst_n <= 1'b0;
            core_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state      <= S_RST_HOLD;
                        len_q      <= len_clamped;
                        wcnt_q     <= '0;
                        core_rst_n <= 1'b0;
                        core_en    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                S_RST_HOLD: begin
                    if (hold_tc) begin
                        if (len_q == '0) begin
                            state      <= S_RUN;
                            core_rst_n <= 1'b1;
                            core_en    <= 1'b1;
                        end else begin
                            state      <= S_LOAD;
                            prog_ready <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        wcnt_q <= wcnt_q + 1'b1;
                        if (last_word) begin
                            state      <= S_RUN;
                            prog_ready <= 1'b0;
                            core_rst_n <= 1'b1;
                            core_en    <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A halt retiring on the budget cycle still counts as a clean halt.
                    if (core_halt || run_tc) begin
                        state   <= S_DONE;
                        core_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= !core_halt;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    prog_ready <= 1'b0;
                    core_rst_n <= 1'b0;
                    core_en    <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset, load handshakes, halt/timeout, abort, clamp.
module tb_mips_run_ctrl;

    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 32;
    localparam int CNT_W        = 16;
    localparam int RESET_CYCLES = 4;
    localparam int MAX_CYCLES   = 20;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              prog_valid = 1'b0;
    logic [DATA_W-1:0] prog_data = '0;
    logic              core_halt = 1'b0;
    logic              prog_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_rst_n;
    logic              core_en;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wr_addr [$];
    logic [DATA_W-1:0] wr_data [$];
    bit                pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    mips_run_ctrl #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .load_len   (load_len),
        .prog_valid (prog_valid),
        .prog_data  (prog_data),
        .prog_ready (prog_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .core_en    (core_en),
        .core_halt  (core_halt),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_cnt  (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 2ns after the rising edge, so the falling edge sees what the next edge writes.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic kick(input logic [ADDR_W:0] len);
        start    = 1'b1;
        load_len = len;
        next();
        start    = 1'b0;
    endtask

    initial begin
        int n;
        int w;

        // Reset state
        #1;
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_core_en", core_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_prog_ready", prog_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        next();
        next();
        rst_n = 1'b1;
        next();

        // Load four words with gaps, then halt in the 10th run cycle
        wr_addr.delete();
        wr_data.delete();
        kick(5'd4);
        check("hold_busy", busy, 1);
        check("hold_core_rst_n", core_rst_n, 0);
        n = 0;
        while (!prog_ready && n < 20) begin
            n++;
            next();
        end
        check("rst_hold_cycles", n, RESET_CYCLES);
        check("load_core_rst_n", core_rst_n, 0);
        w = 0;
        foreach (pat[i]) begin
            prog_valid = pat[i];
            prog_data  = pat[i] ? (32'hA000_0000 | w) : 32'hDEAD_BEEF;
            #1;
            check("load_we", imem_we, pat[i]);
            if (pat[i]) begin
                check("load_addr", imem_addr, w);
                w++;
            end
            next();
        end
        prog_valid = 1'b1;
        prog_data  = '1;
        #1;
        check("run1_prog_ready", prog_ready, 0);
        check("run1_no_extra_we", imem_we, 0);
        check("run1_core_en", core_en, 1);
        check("run1_core_rst_n", core_rst_n, 1);
        next();
        prog_valid = 1'b0;
        for (int r = 2; r < 10; r++) next();
        check("run10_done_low", done, 0);
        core_halt = 1'b1;
        next();
        core_halt = 1'b0;
        check("halt_done", done, 1);
        check("halt_timeout", timeout, 0);
        check("halt_cycle_cnt", cycle_cnt, 10);
        check("halt_core_en", core_en, 0);
        check("halt_core_rst_n", core_rst_n, 1);
        check("halt_busy", busy, 0);
        check("load_write_count", wr_addr.size(), 4);
        for (int i = 0; i < wr_addr.size() && i < 4; i++) begin
            check("load_wr_addr", wr_addr[i], i);
            check("load_wr_data", wr_data[i], 32'hA000_0000 | i);
        end
        next();
        next();
        check("done_held", done, 1);
        check("cnt_frozen", cycle_cnt, 10);

        // Restart from DONE with no program; start pulse in RUN ignored; budget timeout
        wr_addr.delete();
        wr_data.delete();
        kick(5'd0);
        check("restart_done_clr", done, 0);
        check("restart_cnt_clr", cycle_cnt, 0);
        check("restart_busy", busy, 1);
        check("restart_core_rst_n", core_rst_n, 0);
        repeat (RESET_CYCLES) next();
        check("len0_core_en", core_en, 1);
        for (int r = 1; r < 20; r++) begin
            start = (r == 3);
            next();
        end
        start = 1'b0;
        check("start_in_run_ignored", core_en, 1);
        check("run20_done_low", done, 0);
        next();
        check("to_done", done, 1);
        check("to_timeout", timeout, 1);
        check("to_cycle_cnt", cycle_cnt, 20);
        check("to_core_en", core_en, 0);
        check("len0_no_writes", wr_addr.size(), 0);

        // Halt on the budget cycle wins over timeout
        kick(5'd0);
        check("restart_timeout_clr", timeout, 0);
        repeat (RESET_CYCLES) next();
        for (int r = 1; r < 20; r++) next();
        core_halt = 1'b1;
        next();
        core_halt = 1'b0;
        check("tie_done", done, 1);
        check("tie_timeout", timeout, 0);
        check("tie_cycle_cnt", cycle_cnt, 20);

        // Abort during LOAD after two words
        wr_addr.delete();
        wr_data.delete();
        kick(5'd4);
        repeat (RESET_CYCLES) next();
        check("abort_in_load", prog_ready, 1);
        prog_valid = 1'b1;
        prog_data  = 32'hC000_0000;
        next();
        prog_data  = 32'hC000_0001;
        next();
        prog_valid = 1'b0;
        abort      = 1'b1;
        next();
        abort = 1'b0;
        check("abort_prog_ready", prog_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_core_rst_n", core_rst_n, 0);
        check("abort_cycle_cnt", cycle_cnt, 0);
        check("abort_writes", wr_addr.size(), 2);
        next();
        check("abort_stays_idle", busy, 0);
        kick(5'd0);
        repeat (RESET_CYCLES) next();
        check("post_abort_run", core_en, 1);
        check("post_abort_prog_ready", prog_ready, 0);
        core_halt = 1'b1;
        next();
        core_halt = 1'b0;
        check("first_cycle_halt_cnt", cycle_cnt, 1);
        check("first_cycle_halt_done", done, 1);
        check("post_abort_no_writes", wr_addr.size(), 2);

        // Oversized load_len clamps to the imem depth
        wr_addr.delete();
        wr_data.delete();
        kick(5'd20);
        repeat (RESET_CYCLES) next();
        n = 0;
        while (prog_ready && n < 30) begin
            prog_valid = 1'b1;
            prog_data  = 32'hB000_0000 | n;
            n++;
            next();
        end
        prog_valid = 1'b0;
        check("clamp_words", n, 16);
        check("clamp_writes", wr_addr.size(), 16);
        if (wr_addr.size() == 16) check("clamp_last_addr", wr_addr[15], 15);
        check("clamp_core_en", core_en, 1);
        abort = 1'b1;
        next();
        abort = 1'b0;
        check("abort_run_core_en", core_en, 0);
        check("abort_run_core_rst_n", core_rst_n, 0);
        check("abort_run_busy", busy, 0);

        // Async reset in the middle of a run
        kick(5'd0);
        repeat (RESET_CYCLES) next();
        repeat (5) next();
        check("pre_reset_core_en", core_en, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_core_rst_n", core_rst_n, 0);
        check("mid_reset_core_en", core_en, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_cycle_cnt", cycle_cnt, 0);
        next();
        rst_n = 1'b1;
        next();
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);
        check("post_reset_prog_ready", prog_ready, 0);
        kick(5'd0);
        check("post_reset_start", busy, 1);
        repeat (RESET_CYCLES) next();
        check("post_reset_run", core_en, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
